// File: rtl/hazard_sched.sv
// hazard_sched: hazard and stall/flush scheduler for the 5-stage LA32R pipeline.
// Produces operand forwarding selects, load-use stalls, branch flushes and
// data-RAM wait-state freezes. Owns the data-RAM handshake FSM and the
// stall/flush performance counters.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | no outstanding RAM access; dram_req follows mem_req
//   MEM_WAIT | access issued but not yet acknowledged; pipeline frozen
//
// A data-RAM access is acknowledged combinationally. The freeze, and every
// stall/flush derived from it, must therefore drop in the same cycle that
// dram_ack rises. For that reason the control outputs are decoded from the
// registered state and the current inputs rather than being registered.
module hazard_sched #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic [4:0]       id_rR1,
  input  logic [4:0]       id_rR2,
  input  logic             id_rR1_re,
  input  logic             id_rR2_re,
  input  logic [4:0]       ex_wr,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_wr,
  input  logic             mem_rf_we,
  input  logic [4:0]       wb_wr,
  input  logic             wb_rf_we,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             dram_ack,
  output logic             dram_req,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The wait timer counts down from WAIT_MAX-1. Terminal count 0 seen in a
  // non-acknowledged wait cycle marks the WAIT_MAX-th consecutive wait cycle.
  localparam int               WW        = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0]    WAIT_LOAD = WW'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t          state;
  logic [WW-1:0]   wait_left;
  logic            bus_err_q;

  logic            ex_hit1, ex_hit2;
  logic            mem_hit1, mem_hit2;
  logic            wb_hit1, wb_hit2;
  logic [1:0]      fwd1_raw, fwd2_raw;
  logic            lu, fz, br_eff, lu_eff;
  logic            req_raw;

  // A destination register can only be forwarded from if it is written and is not r0.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic we);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  // Per-operand forwarding priority: the youngest producer wins.
  always_comb begin
    ex_hit1  = reg_match(id_rR1, ex_wr,  ex_rf_we);
    ex_hit2  = reg_match(id_rR2, ex_wr,  ex_rf_we);
    mem_hit1 = reg_match(id_rR1, mem_wr, mem_rf_we);
    mem_hit2 = reg_match(id_rR2, mem_wr, mem_rf_we);
    wb_hit1  = reg_match(id_rR1, wb_wr,  wb_rf_we);
    wb_hit2  = reg_match(id_rR2, wb_wr,  wb_rf_we);

    fwd1_raw = 2'b00;
    if (ex_hit1)       fwd1_raw = 2'b01;
    else if (mem_hit1) fwd1_raw = 2'b10;
    else if (wb_hit1)  fwd1_raw = 2'b11;

    fwd2_raw = 2'b00;
    if (ex_hit2)       fwd2_raw = 2'b01;
    else if (mem_hit2) fwd2_raw = 2'b10;
    else if (wb_hit2)  fwd2_raw = 2'b11;
  end

  // Hazard arbitration: freeze masks everything, and a taken branch squashes
  // the ID instruction, which makes a load-use stall on it pointless.
  always_comb begin
    lu = ex_is_load && ((id_rR1_re && ex_hit1) || (id_rR2_re && ex_hit2));

    fz      = 1'b0;
    req_raw = 1'b0;
    case (state)
      RUN: begin
        req_raw = mem_req;
        fz      = mem_req && !dram_ack;
      end
      MEM_WAIT: begin
        req_raw = 1'b1;
        fz      = !dram_ack;
      end
      default: begin
        req_raw = 1'b0;
        fz      = 1'b0;
      end
    endcase

    br_eff = ex_br_taken && !fz;
    lu_eff = lu && !fz && !ex_br_taken;
  end

  // Every output is held low while reset is asserted, including the
  // combinational ones; this makes dram_req drop as soon as reset asserts.
  assign dram_req     = cpu_rstn && req_raw;
  assign fwd1_sel     = cpu_rstn ? fwd1_raw : 2'b00;
  assign fwd2_sel     = cpu_rstn ? fwd2_raw : 2'b00;
  assign pc_stall     = cpu_rstn && (fz || lu_eff);
  assign if_id_stall  = cpu_rstn && (fz || lu_eff);
  assign id_ex_stall  = cpu_rstn && fz;
  assign ex_mem_stall = cpu_rstn && fz;
  assign mem_wb_flush = cpu_rstn && fz;
  assign if_id_flush  = cpu_rstn && br_eff;
  assign id_ex_flush  = cpu_rstn && (br_eff || lu_eff);
  assign bus_err      = cpu_rstn && bus_err_q;

  // RAM handshake FSM with wait timer and sticky timeout flag.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state     <= RUN;
      wait_left <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !dram_ack) begin
            state     <= MEM_WAIT;
            wait_left <= WAIT_LOAD;
          end
        end
        MEM_WAIT: begin
          if (dram_ack) begin
            state <= RUN;
          end else if (wait_left == '0) begin
            bus_err_q <= 1'b1;
            state     <= RUN;
          end else begin
            wait_left <= wait_left - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_ONE;
      if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed bench for hazard_sched. A rule-level model is
// checked against the DUT every cycle, and literal expectations pin key points.
module tb_hazard_sched;

  localparam int CNT_W    = 8;
  localparam int WAIT_MAX = 255;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             cpu_clk = 1'b0;
  logic             cpu_rstn = 1'b1;
  logic [4:0]       id_rR1 = '0, id_rR2 = '0, ex_wr = '0, mem_wr = '0, wb_wr = '0;
  logic             id_rR1_re = 0, id_rR2_re = 0, ex_rf_we = 0, ex_is_load = 0;
  logic             mem_rf_we = 0, wb_rf_we = 0, ex_br_taken = 0, mem_req = 0, dram_ack = 0;
  logic             dram_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic             if_id_flush, id_ex_flush, mem_wb_flush, bus_err;
  logic [1:0]       fwd1_sel, fwd2_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_sched #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .id_rR1(id_rR1), .id_rR2(id_rR2), .id_rR1_re(id_rR1_re), .id_rR2_re(id_rR2_re),
    .ex_wr(ex_wr), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .mem_wr(mem_wr), .mem_rf_we(mem_rf_we), .wb_wr(wb_wr), .wb_rf_we(wb_rf_we),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .dram_ack(dram_ack),
    .dram_req(dram_req), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .bus_err(bus_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic m_wait   = 1'b0;
  int   m_waited = 0;
  logic m_berr   = 1'b0;
  int   m_sc     = 0;
  int   m_fc     = 0;

  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst, input logic we);
    return we && (dst != 0) && (dst == src);
  endfunction

  function automatic logic [1:0] pick(input logic [4:0] src);
    if (hit(src, ex_wr, ex_rf_we))   return 2'b01;
    if (hit(src, mem_wr, mem_rf_we)) return 2'b10;
    if (hit(src, wb_wr, wb_rf_we))   return 2'b11;
    return 2'b00;
  endfunction

  // RAM has not finished: either a fresh request or an outstanding one without ack.
  function automatic logic frz_now();
    return !dram_ack && (m_wait || mem_req);
  endfunction

  function automatic logic lu_now();
    return ex_is_load && ((id_rR1_re && hit(id_rR1, ex_wr, ex_rf_we)) ||
                          (id_rR2_re && hit(id_rR2, ex_wr, ex_rf_we)));
  endfunction

  function automatic logic stall_now();
    return frz_now() || (lu_now() && !ex_br_taken);
  endfunction

  function automatic logic iflush_now();
    return !frz_now() && ex_br_taken;
  endfunction

  function automatic logic eflush_now();
    return !frz_now() && (ex_br_taken || lu_now());
  endfunction

  always @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      m_wait <= 1'b0; m_waited <= 0; m_berr <= 1'b0; m_sc <= 0; m_fc <= 0;
    end else begin
      if (stall_now() && m_sc < CMAX)  m_sc <= m_sc + 1;
      if (iflush_now() && m_fc < CMAX) m_fc <= m_fc + 1;
      if (m_wait) begin
        if (dram_ack) m_wait <= 1'b0;
        else if (m_waited + 1 >= WAIT_MAX) begin
          m_berr <= 1'b1;
          m_wait <= 1'b0;
        end else m_waited <= m_waited + 1;
      end else if (mem_req && !dram_ack) begin
        m_wait   <= 1'b1;
        m_waited <= 0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge cpu_clk) begin
    logic r;
    r = cpu_rstn;
    chk("dram_req",     dram_req,     r && (m_wait || mem_req));
    chk("fwd1_sel",     fwd1_sel,     r ? pick(id_rR1) : 2'b00);
    chk("fwd2_sel",     fwd2_sel,     r ? pick(id_rR2) : 2'b00);
    chk("pc_stall",     pc_stall,     r && stall_now());
    chk("if_id_stall",  if_id_stall,  r && stall_now());
    chk("id_ex_stall",  id_ex_stall,  r && frz_now());
    chk("ex_mem_stall", ex_mem_stall, r && frz_now());
    chk("mem_wb_flush", mem_wb_flush, r && frz_now());
    chk("if_id_flush",  if_id_flush,  r && iflush_now());
    chk("id_ex_flush",  id_ex_flush,  r && eflush_now());
    chk("bus_err",      bus_err,      r && m_berr);
    chk("stall_cnt",    stall_cnt,    r ? m_sc : 0);
    chk("flush_cnt",    flush_cnt,    r ? m_fc : 0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge cpu_clk);
    #1;
  endtask

  task automatic clr();
    id_rR1 = 0; id_rR2 = 0; id_rR1_re = 0; id_rR2_re = 0;
    ex_wr = 0; ex_rf_we = 0; ex_is_load = 0; mem_wr = 0; mem_rf_we = 0;
    wb_wr = 0; wb_rf_we = 0; ex_br_taken = 0; mem_req = 0; dram_ack = 0;
  endtask

  initial begin
    int n;
    #1 cpu_rstn = 1'b0;
    // reset: outputs forced low even with active inputs
    mem_req = 1; ex_wr = 5; ex_rf_we = 1; id_rR1 = 5;
    mid();
    chk("rst_dram_req", dram_req, 0);
    chk("rst_fwd1", fwd1_sel, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    clr();
    cyc();
    cpu_rstn = 1'b1;

    // forwarding priority
    cyc();
    ex_wr = 5; ex_rf_we = 1; mem_wr = 5; mem_rf_we = 1; id_rR1 = 5; id_rR1_re = 1;
    id_rR2 = 9; wb_wr = 9; wb_rf_we = 1;
    mid();
    chk("fwd_ex_wins", fwd1_sel, 2'b01);
    chk("fwd_wb", fwd2_sel, 2'b11);
    cyc();
    ex_rf_we = 0; id_rR1_re = 0;
    mid();
    chk("fwd_mem", fwd1_sel, 2'b10);
    cyc();
    ex_wr = 0; mem_wr = 0; wb_wr = 0; ex_rf_we = 1; id_rR1 = 0; id_rR2 = 0;
    mid();
    chk("fwd_r0_1", fwd1_sel, 2'b00);
    chk("fwd_r0_2", fwd2_sel, 2'b00);

    // load-use
    cyc();
    clr();
    ex_is_load = 1; ex_wr = 7; ex_rf_we = 1; id_rR2 = 7; id_rR2_re = 1;
    mid();
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_id_ex_stall", id_ex_stall, 0);
    cyc();
    id_rR2_re = 0;
    mid();
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_no_re", pc_stall, 0);

    // branch and load-use together
    cyc();
    id_rR2_re = 1; ex_br_taken = 1;
    mid();
    chk("br_lu_ifflush", if_id_flush, 1);
    chk("br_lu_exflush", id_ex_flush, 1);
    chk("br_lu_pc_stall", pc_stall, 0);
    cyc();
    clr();
    mid();
    chk("br_flush_cnt", flush_cnt, 1);

    // zero-wait access
    cyc();
    mem_req = 1; dram_ack = 1;
    mid();
    chk("zw_req", dram_req, 1);
    chk("zw_stall", pc_stall, 0);

    // three wait cycles then ack
    cyc();
    dram_ack = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("wait_req", dram_req, 1);
      chk("wait_mwbf", mem_wb_flush, 1);
      chk("wait_exmem", ex_mem_stall, 1);
      cyc();
    end
    dram_ack = 1;
    mid();
    chk("ack_req", dram_req, 1);
    chk("ack_mwbf", mem_wb_flush, 0);
    cyc();
    clr();
    mid();
    chk("wait_done_req", dram_req, 0);
    chk("wait_stall_cnt", stall_cnt, 4);

    // branch held through a 2-cycle wait
    cyc();
    mem_req = 1; ex_br_taken = 1;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("brw_no_flush", if_id_flush, 0);
      cyc();
    end
    dram_ack = 1;
    mid();
    chk("brw_rel_ifflush", if_id_flush, 1);
    chk("brw_rel_exflush", id_ex_flush, 1);
    chk("brw_rel_stall", pc_stall, 0);
    cyc();
    clr();
    mid();
    chk("brw_stall_cnt", stall_cnt, 6);
    chk("brw_flush_cnt", flush_cnt, 2);

    // timeout
    cyc();
    mem_req = 1;
    n = 0;
    while (!bus_err && n < 400) begin
      cyc();
      n++;
    end
    chk("timeout_cycles", n, WAIT_MAX + 1);
    mem_req = 0;
    mid();
    chk("timeout_run", dram_req, 0);
    chk("timeout_err", bus_err, 1);
    chk("stall_sat", stall_cnt, CMAX);

    // reset in the middle of a wait
    cyc();
    mem_req = 1;
    cyc();
    cyc();
    #2 cpu_rstn = 1'b0;
    #1;
    chk("rstw_req", dram_req, 0);
    chk("rstw_err", bus_err, 0);
    chk("rstw_stall_cnt", stall_cnt, 0);
    chk("rstw_flush_cnt", flush_cnt, 0);
    mem_req = 0;
    cyc();
    cpu_rstn = 1'b1;
    mem_req = 1;
    mid();
    chk("rstw_after_req", dram_req, 1);
    cyc();
    dram_ack = 1;
    cyc();
    clr();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
